interval_timer: RTL and testbench
=================================

# interval_timer

Memory-mapped interval timer that sits directly upstream of the coprocessor-0 block. It produces the `TimerInterrupt` level that coprocessor 0 samples into Cause bit 15. It keeps a free-running 32-bit cycle counter, raises an interrupt when the counter reaches a programmable compare value, and optionally re-arms itself with a programmable period. Software reads and writes it through load/store addresses decoded in parallel with data memory.

## Interface
Parameters: none.

- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the clock edge where it is high
- `address`  in  32  load/store byte address from the datapath
- `data`  in  32  store data
- `MemRead`  in  1  load in progress this cycle
- `MemWrite`  in  1  store in progress this cycle
- `TimerInterrupt`  out  1  registered interrupt request to coprocessor 0; level-held until acknowledged
- `TimerAddress`  out  1  combinational; high when `address` is one of the three timer addresses; steers the load mux and suppresses the data-memory write
- `cycle`  out  32  combinational load data for timer reads; 0 when not reading a timer address

## Operation
- Address map, word-exact match, no partial decode:
  - `0xFFFF001C`: read cycle count; write compare value.
  - `0xFFFF0024`: read/write period.
  - `0xFFFF006C`: read returns `{31'b0, TimerInterrupt}`; any write acknowledges, and the data is ignored.
- `TimerAddress` = address matches any of the three, independent of `MemRead`/`MemWrite`.
- `cycle_count`: reset 0; increments by 1 every cycle, including the cycle of any write; wraps `0xFFFFFFFF` → 0.
- `compare`: reset `0xFFFFFFFF`.
  - Loaded from `data` on `MemWrite` to `0x...001C`.
  - Otherwise, when a match occurs and `period != 0`, `compare <= compare + period` (mod 2^32).
  - A software write has priority over auto-reload.
- `period`: reset 0; loaded from `data` on `MemWrite` to `0x...0024`. `period == 0` means one-shot.
- Match is the combinational condition `cycle_count == compare`, using the current register values.
- Interrupt flag (drives `TimerInterrupt`): reset 0.
  - Set on the edge after a match.
  - Cleared on the edge after `MemWrite` to `0x...006C`.
  - If a match and an acknowledge occur in the same cycle, set wins and the flag stays 1.
  - Otherwise the flag holds.
- Reads: `cycle` = `cycle_count` / `period` / flag word when `MemRead` is high and the address matches. Otherwise `cycle` = 0.
- `MemRead` and `MemWrite` both high at the same address: write takes effect at the edge; read returns the pre-edge value.
- Reset mid-operation: the counter, compare, period and flag all return to reset values at that edge. A pending interrupt is dropped. The match on the reset cycle is ignored.

## Timing
- All state is registered. `TimerInterrupt` has 1-cycle latency from match.
- A compare value written at edge E participates in matching from the cycle after E. `cycle_count` is then (value at E) + 1. Writing a value equal to the current count therefore does not fire until wrap.
- Auto-reload: a match at count N with period P produces the next match at count N+P. The interrupt flag is already set and remains set until acknowledged. Unacknowledged matches do not queue.
- Acknowledge followed by a new match: the flag falls for at least one cycle unless the match is in the acknowledge cycle.
- `TimerAddress` and `cycle` are purely combinational from the inputs and current state. They have no registered delay.
- After reset deasserts, the first count seen is 0. With `compare = 0xFFFFFFFF` and `period = 0` there is no interrupt for 2^32−1 cycles.

## Test plan
- Reset, then idle 20 cycles → `TimerInterrupt` = 0. A load from `0xFFFF001C` at cycle 20 after reset returns 20. A load from `0xFFFF0024` returns 0.
- Store 50 to `0xFFFF001C` at count 10 → `TimerInterrupt` rises the cycle after count 50. It stays high for 30 idle cycles. A store to `0xFFFF006C` drops it the next cycle, and it stays low.
- Store period 16, compare 40 → interrupts set after counts 40, 56, 72. Acknowledge each in between. Reading `0xFFFF006C` returns 1 before each acknowledge and 0 after.
- Set compare so that the match and the acknowledge store land in the same cycle → `TimerInterrupt` remains 1 the following cycle.
- Store compare = current count → no interrupt in the next 100 cycles. During a store to `0x...001C`, `TimerAddress` = 1. Store to `0xFFFF0020` → `TimerAddress` = 0 and no state changes.
- Assert `reset` for 1 cycle while `TimerInterrupt` = 1 and period = 8 → next cycle the flag is 0, the count is 0, and the period reads 0.

Source files
------------

// File: rtl/interval_timer.sv
// Memory-mapped interval timer: a free-running cycle counter, a compare register
// with optional periodic auto-reload, and a level interrupt held until acknowledged.
module interval_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        TimerInterrupt,
  output logic        TimerAddress,
  output logic [31:0] cycle
);

  localparam logic [31:0] ADDR_COUNT  = 32'hFFFF_001C;
  localparam logic [31:0] ADDR_PERIOD = 32'hFFFF_0024;
  localparam logic [31:0] ADDR_FLAG   = 32'hFFFF_006C;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] period_q, period_d;
  logic        flag_q, flag_d;

  logic sel_count, sel_period, sel_flag;
  logic match;

  always_comb begin
    sel_count    = (address == ADDR_COUNT);
    sel_period   = (address == ADDR_PERIOD);
    sel_flag     = (address == ADDR_FLAG);
    TimerAddress = sel_count | sel_period | sel_flag;
    match        = (count_q == compare_q);

    cycle = 32'd0;
    if (MemRead) begin
      if (sel_count)       cycle = count_q;
      else if (sel_period) cycle = period_q;
      else if (sel_flag)   cycle = {31'd0, flag_q};
    end
  end

  always_comb begin
    count_d = count_q + 32'd1;

    // A software store to the compare register overrides the periodic re-arm.
    compare_d = compare_q;
    if (MemWrite && sel_count)                compare_d = data;
    else if (match && (period_q != 32'd0))    compare_d = compare_q + period_q;

    period_d = period_q;
    if (MemWrite && sel_period) period_d = data;

    // A match in the acknowledge cycle keeps the interrupt asserted.
    flag_d = flag_q;
    if (match)                        flag_d = 1'b1;
    else if (MemWrite && sel_flag)    flag_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      period_q  <= 32'd0;
      flag_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      period_q  <= period_d;
      flag_q    <= flag_d;
    end
  end

  assign TimerInterrupt = flag_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: reset state, one-shot, periodic reload,
// acknowledge/match collision, address decode and mid-run reset.
module tb_interval_timer;

  localparam logic [31:0] A_CNT = 32'hFFFF_001C;
  localparam logic [31:0] A_PER = 32'hFFFF_0024;
  localparam logic [31:0] A_FLG = 32'hFFFF_006C;
  localparam logic [31:0] A_BAD = 32'hFFFF_0020;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] data = 32'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        timer_interrupt;
  logic        timer_address;
  logic [31:0] cycle;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  interval_timer dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .data          (data),
    .MemRead       (mem_read),
    .MemWrite      (mem_write),
    .TimerInterrupt(timer_interrupt),
    .TimerAddress  (timer_address),
    .cycle         (cycle)
  );

  always #5 clock = ~clock;

  // Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
    exp_cnt++;
  endtask

  task automatic idle();
    address   = 32'd0;
    data      = 32'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    address   = a;
    data      = d;
    mem_write = 1'b1;
    tick();
    idle();
  endtask

  task automatic load(input logic [31:0] a);
    address  = a;
    mem_read = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (timer_interrupt !== 1'b0) begin
      failures++; $display("FAIL reset_irq got=%0b exp=0", timer_interrupt);
    end
    repeat (20) tick();
    checks++;
    if (timer_interrupt !== 1'b0) begin
      failures++; $display("FAIL idle_irq got=%0b exp=0", timer_interrupt);
    end
    address = A_CNT; #1;
    checks++;
    if (cycle !== 32'd0 || timer_address !== 1'b1) begin
      failures++; $display("FAIL noread_zero cycle=%0d taddr=%0b exp 0/1", cycle, timer_address);
    end
    load(A_CNT);
    checks++;
    if (cycle !== 32'd20) begin
      failures++; $display("FAIL read_count got=%0d exp=20", cycle);
    end
    load(A_PER);
    checks++;
    if (cycle !== 32'd0) begin
      failures++; $display("FAIL read_period got=%0d exp=0", cycle);
    end
    idle();
  endtask

  task automatic test_oneshot();
    int early;
    do_reset();
    repeat (10) tick();
    address = A_CNT; data = 32'd50; mem_write = 1'b1; #1;
    checks++;
    if (timer_address !== 1'b1) begin
      failures++; $display("FAIL taddr_store got=%0b exp=1", timer_address);
    end
    tick();
    idle();
    early = 0;
    while (exp_cnt < 50) begin
      if (timer_interrupt !== 1'b0) early++;
      tick();
    end
    checks++;
    if (early != 0 || timer_interrupt !== 1'b0) begin
      failures++; $display("FAIL oneshot_early early=%0d irq=%0b exp 0/0", early, timer_interrupt);
    end
    tick();
    checks++;
    if (timer_interrupt !== 1'b1) begin
      failures++; $display("FAIL oneshot_fire got=%0b exp=1", timer_interrupt);
    end
    early = 0;
    repeat (30) begin
      tick();
      if (timer_interrupt !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      failures++; $display("FAIL oneshot_hold drops=%0d exp=0", early);
    end
    store(A_FLG, 32'h1234);
    checks++;
    if (timer_interrupt !== 1'b0) begin
      failures++; $display("FAIL oneshot_ack got=%0b exp=0", timer_interrupt);
    end
    early = 0;
    repeat (20) begin
      tick();
      if (timer_interrupt !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      failures++; $display("FAIL oneshot_stay_low rises=%0d exp=0", early);
    end
  endtask

  task automatic test_periodic();
    int target;
    do_reset();
    store(A_PER, 32'd16);
    store(A_CNT, 32'd40);
    for (int k = 0; k < 3; k++) begin
      target = 40 + 16 * k;
      while (exp_cnt < target) tick();
      checks++;
      if (timer_interrupt !== 1'b0) begin
        failures++; $display("FAIL periodic_pre k=%0d got=%0b exp=0", k, timer_interrupt);
      end
      tick();
      load(A_FLG);
      checks++;
      if (timer_interrupt !== 1'b1 || cycle !== 32'd1) begin
        failures++; $display("FAIL periodic_set k=%0d irq=%0b rd=%0d exp 1/1", k, timer_interrupt, cycle);
      end
      idle();
      store(A_FLG, 32'd0);
      load(A_FLG);
      checks++;
      if (timer_interrupt !== 1'b0 || cycle !== 32'd0) begin
        failures++; $display("FAIL periodic_ack k=%0d irq=%0b rd=%0d exp 0/0", k, timer_interrupt, cycle);
      end
      idle();
    end
  endtask

  task automatic test_ack_collision();
    do_reset();
    store(A_PER, 32'd10);
    store(A_CNT, 32'd20);
    while (exp_cnt < 30) tick();
    checks++;
    if (timer_interrupt !== 1'b1) begin
      failures++; $display("FAIL collide_pre got=%0b exp=1", timer_interrupt);
    end
    // Count is 30 == reloaded compare while the acknowledge store is on the bus.
    address = A_FLG; mem_write = 1'b1; mem_read = 1'b1; #1;
    checks++;
    if (cycle !== 32'd1) begin
      failures++; $display("FAIL rw_same_read got=%0d exp=1", cycle);
    end
    tick();
    idle();
    checks++;
    if (timer_interrupt !== 1'b1) begin
      failures++; $display("FAIL collide_set_wins got=%0b exp=1", timer_interrupt);
    end
    store(A_FLG, 32'd0);
    checks++;
    if (timer_interrupt !== 1'b0) begin
      failures++; $display("FAIL collide_late_ack got=%0b exp=0", timer_interrupt);
    end
  endtask

  task automatic test_decode();
    int rises;
    do_reset();
    repeat (7) tick();
    address = A_CNT; data = 32'd7; mem_write = 1'b1; mem_read = 1'b1; #1;
    checks++;
    if (cycle !== 32'd7 || timer_address !== 1'b1) begin
      failures++; $display("FAIL rw_count got=%0d taddr=%0b exp 7/1", cycle, timer_address);
    end
    tick();
    idle();
    rises = 0;
    repeat (100) begin
      tick();
      if (timer_interrupt !== 1'b0) rises++;
    end
    checks++;
    if (rises != 0) begin
      failures++; $display("FAIL cmp_eq_count rises=%0d exp=0", rises);
    end
    address = A_BAD; data = exp_cnt + 3; mem_write = 1'b1; mem_read = 1'b1; #1;
    checks++;
    if (timer_address !== 1'b0 || cycle !== 32'd0) begin
      failures++; $display("FAIL bad_addr taddr=%0b rd=%0d exp 0/0", timer_address, cycle);
    end
    tick();
    idle();
    rises = 0;
    repeat (10) begin
      tick();
      if (timer_interrupt !== 1'b0) rises++;
    end
    load(A_PER);
    checks++;
    if (rises != 0 || cycle !== 32'd0) begin
      failures++; $display("FAIL bad_addr_state rises=%0d period=%0d exp 0/0", rises, cycle);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    int rises;
    do_reset();
    store(A_PER, 32'd8);
    store(A_CNT, 32'd5);
    while (exp_cnt < 7) tick();
    checks++;
    if (timer_interrupt !== 1'b1) begin
      failures++; $display("FAIL mreset_pre got=%0b exp=1", timer_interrupt);
    end
    do_reset();
    load(A_CNT);
    checks++;
    if (timer_interrupt !== 1'b0 || cycle !== 32'd0) begin
      failures++; $display("FAIL mreset_state irq=%0b count=%0d exp 0/0", timer_interrupt, cycle);
    end
    load(A_PER);
    checks++;
    if (cycle !== 32'd0) begin
      failures++; $display("FAIL mreset_period got=%0d exp=0", cycle);
    end
    idle();
    rises = 0;
    repeat (20) begin
      tick();
      if (timer_interrupt !== 1'b0) rises++;
    end
    checks++;
    if (rises != 0) begin
      failures++; $display("FAIL mreset_compare rises=%0d exp=0", rises);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_ack_collision();
    test_decode();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
